// File: rtl/sync_debounce.sv
// Multi-channel synchroniser with per-channel stability filter and edge pulses.
// Each channel: STAGES-deep metastability chain, then a counter gating level changes.
module sync_debounce #(
  parameter int unsigned       WIDTH  = 1,
  parameter int unsigned       STAGES = 3,
  parameter logic [WIDTH-1:0]  INIT   = '0,
  parameter int unsigned       FILTER = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             stable
);

  localparam int unsigned CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER - 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_debounce: WIDTH must be in 1..32");
  end
  if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
    $error("sync_debounce: STAGES must be in 2..8");
  end
  if (FILTER < 1 || FILTER > 255) begin : g_bad_filter
    $error("sync_debounce: FILTER must be in 1..255");
  end

  logic [WIDTH-1:0] cnt_zero;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [STAGES-1:0] sync_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              s;

    assign s = sync_q[STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q <= {STAGES{INIT[i]}};
      end else begin
        sync_q <= {sync_q[STAGES-2:0], data_in[i]};
      end
    end

    // A level change commits only on the FILTER-th consecutive disagreeing cycle.
    always_comb begin
      cnt_d  = '0;
      out_d  = out_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s != out_q) begin
        if (cnt_q == CNT_MAX) begin
          out_d  = s;
          rise_d = s;
          fall_d = ~s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        out_q  <= INIT[i];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        out_q  <= out_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign data_out[i] = out_q;
    assign rise[i]     = rise_q;
    assign fall[i]     = fall_q;
    assign cnt_zero[i] = (cnt_q == '0);
  end

  assign stable = &cnt_zero;

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: three parameterisations, directed scenarios plus
// randomized traffic checked every cycle against a sample-window model.
module tb_sync_debounce;

  localparam int ND = 3;
  localparam int ST [ND] = '{3, 2, 5};
  localparam int FL [ND] = '{4, 1, 7};
  localparam logic [3:0] INI [ND] = '{4'b1000, 4'b1010, 4'b0110};

  logic       clk;
  logic       reset;
  logic       run;
  logic [3:0] din  [ND];
  logic [3:0] dout [ND];
  logic [3:0] rise [ND];
  logic [3:0] fall [ND];
  logic [2:0] stab;

  int checks   = 0;
  int failures = 0;

  // model state: capture history (index 0 = newest) and chain-output history
  logic [3:0] cap  [ND][16];
  logic [3:0] sh   [ND][16];
  int         ncap [ND];
  int         nsh  [ND];
  logic [3:0] mout [ND];
  logic [3:0] mrise[ND];
  logic [3:0] mfall[ND];
  logic       mstab[ND];

  sync_debounce #(.WIDTH(4), .STAGES(3), .INIT(4'b1000), .FILTER(4)) u_a (
    .clk(clk), .reset(reset), .data_in(din[0]), .data_out(dout[0]),
    .rise(rise[0]), .fall(fall[0]), .stable(stab[0]));
  sync_debounce #(.WIDTH(4), .STAGES(2), .INIT(4'b1010), .FILTER(1)) u_b (
    .clk(clk), .reset(reset), .data_in(din[1]), .data_out(dout[1]),
    .rise(rise[1]), .fall(fall[1]), .stable(stab[1]));
  sync_debounce #(.WIDTH(4), .STAGES(5), .INIT(4'b0110), .FILTER(7)) u_c (
    .clk(clk), .reset(reset), .data_in(din[2]), .data_out(dout[2]),
    .rise(rise[2]), .fall(fall[2]), .stable(stab[2]));

  initial clk = 1'b0;
  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mreset(int d);
    ncap[d]  = 0;
    nsh[d]   = 0;
    mout[d]  = INI[d];
    mrise[d] = '0;
    mfall[d] = '0;
    mstab[d] = 1'b1;
  endfunction

  // Chain output at an edge is the input captured STAGES edges earlier (INIT
  // before that); a bit changes when the last FILTER chain samples all disagree.
  function automatic void mstep(int d, logic [3:0] dv);
    logic [3:0] s, prev;
    logic       all;
    s = (ncap[d] >= ST[d]) ? cap[d][ST[d]-1] : INI[d];
    for (int k = 15; k > 0; k--) begin
      cap[d][k] = cap[d][k-1];
      sh[d][k]  = sh[d][k-1];
    end
    cap[d][0] = dv;
    sh[d][0]  = s;
    if (ncap[d] < 16) ncap[d]++;
    if (nsh[d] < 16) nsh[d]++;
    prev = mout[d];
    for (int i = 0; i < 4; i++) begin
      if (s[i] != prev[i] && nsh[d] >= FL[d]) begin
        all = 1'b1;
        for (int j = 0; j < FL[d]; j++)
          if (sh[d][j][i] != s[i]) all = 1'b0;
        if (all) mout[d][i] = s[i];
      end
    end
    mrise[d] = mout[d] & ~prev;
    mfall[d] = prev & ~mout[d];
    mstab[d] = (s == mout[d]);
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < ND; d++) begin
      if (reset) mreset(d);
      else       mstep(d, din[d]);
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("cmp%0d_data_out", d), 32'(dout[d]), 32'(mout[d]));
      chk($sformatf("cmp%0d_rise", d),     32'(rise[d]), 32'(mrise[d]));
      chk($sformatf("cmp%0d_fall", d),     32'(fall[d]), 32'(mfall[d]));
      chk($sformatf("cmp%0d_stable", d),   32'(stab[d]), 32'(mstab[d]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic bad;
  int   rate;

  initial begin
    run   = 1'b0;
    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      din[d] = INI[d];
      mreset(d);
    end
    #1 reset = 1'b1;
    #20;
    // reset with clock stopped
    chk("rst_b_data_out", 32'(dout[1]), 32'h0000000a);
    chk("rst_b_rise",     32'(rise[1]), 32'h0);
    chk("rst_b_fall",     32'(fall[1]), 32'h0);
    chk("rst_b_stable",   32'(stab[1]), 32'h1);
    chk("rst_a_data_out", 32'(dout[0]), 32'h00000008);
    chk("rst_c_data_out", 32'(dout[2]), 32'h00000006);

    run = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) tick();
    chk("release_no_pulse", 32'({rise[0], fall[0], rise[1], fall[1]}), 32'h0);

    // step on channel 0: out after edge 7, counting during 4..6
    din[0][0] = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("step_out_e%0d", e),    32'(dout[0][0]), 32'(e >= 7));
      chk($sformatf("step_rise_e%0d", e),   32'(rise[0][0]), 32'(e == 7));
      chk($sformatf("step_stable_e%0d", e), 32'(stab[0]),    32'(!(e >= 4 && e <= 6)));
    end

    // 3-cycle glitch on channel 1 is swallowed
    din[0][1] = 1'b1;
    bad = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      if (e == 4) din[0][1] = 1'b0;
      tick();
      if (dout[0][1] || rise[0][1] || fall[0][1]) bad = 1'b1;
      chk($sformatf("glitch_stable_e%0d", e), 32'(stab[0]), 32'(!(e >= 4 && e <= 6)));
    end
    chk("glitch_no_change", 32'(bad), 32'h0);
    chk("glitch_out", 32'(dout[0]), 32'h00000009);

    // simultaneous rise on ch2 and fall on ch3
    din[0][2] = 1'b1;
    din[0][3] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("dual_rise2_e%0d", e), 32'(rise[0][2]), 32'(e == 7));
      chk($sformatf("dual_fall3_e%0d", e), 32'(fall[0][3]), 32'(e == 7));
      chk($sformatf("dual_x_e%0d", e),     32'({rise[0][3], fall[0][2]}), 32'h0);
    end

    // reset mid-count discards the pending change; full latency applies again
    din[0] = 4'b1000;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    din[0][0] = 1'b1;
    repeat (5) tick();
    chk("midrst_pre_out", 32'(dout[0][0]), 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out",    32'(dout[0]), 32'h00000008);
    chk("midrst_pulses", 32'({rise[0], fall[0]}), 32'h0);
    chk("midrst_stable", 32'(stab[0]), 32'h1);
    #1 reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk($sformatf("midrst_out_e%0d", e),  32'(dout[0][0]), 32'(e >= 7));
      chk($sformatf("midrst_rise_e%0d", e), 32'(rise[0][0]), 32'(e == 7));
    end

    // STAGES=2, FILTER=1: out after edge 3
    din[1][0] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("f1_out_e%0d", e),  32'(dout[1][0]), 32'(e >= 3));
      chk($sformatf("f1_rise_e%0d", e), 32'(rise[1][0]), 32'(e == 3));
    end

    // randomized traffic with occasional asynchronous reset pulses
    rate = 8;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 200 == 0) rate = 1 << $urandom_range(4, 1);
      for (int d = 0; d < ND; d++)
        for (int i = 0; i < 4; i++)
          if ($urandom_range(rate - 1, 0) == 0) din[d][i] = ~din[d][i];
      if ($urandom_range(255, 0) == 0) begin
        #1 reset = 1'b1;
        #4 reset = 1'b0;
      end
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
